// File: rtl/fsm_bus_responder.sv
// fsm_bus_responder: single-slave bus responder with WAIT_CYCLES wait states and DEPTH-word storage.
// Optional feature macro: BUS_RESP_ERR_EN adds the o_err out-of-range flag.
`default_nettype none

module fsm_bus_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sel,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_ok,
`ifdef BUS_RESP_ERR_EN
  output logic              o_err,
`endif
  output logic [2:0]        o_stat_current
);

  typedef enum logic [2:0] {
    ST_RST  = 3'b000,
    ST_IDLE = 3'b001,
    ST_BUSY = 3'b010,
    ST_ACK  = 3'b011
  } state_t;

  localparam logic [3:0]      WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  // One extra bit so DEPTH == 2**ADDR_W compares correctly.
  assign in_range       = ({1'b0, cap_addr} < DEPTH_L);
  assign o_stat_current = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_RST;
      wait_cnt  <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      o_ok      <= 1'b0;
      o_rdata   <= '0;
`ifdef BUS_RESP_ERR_EN
      o_err     <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      o_ok  <= 1'b0;
`ifdef BUS_RESP_ERR_EN
      o_err <= 1'b0;
`endif
      case (state)
        ST_RST: state <= ST_IDLE;
        ST_IDLE: begin
          if (i_sel) begin
            cap_write <= i_write;
            cap_addr  <= i_addr;
            cap_wdata <= i_wdata;
            wait_cnt  <= WAIT_LD;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_ACK;
            o_ok  <= 1'b1;
`ifdef BUS_RESP_ERR_EN
            o_err <= ~in_range;
`endif
            // Out-of-range writes are dropped; out-of-range reads return zero.
            if (cap_write) begin
              if (in_range) begin
                mem[cap_addr] <= cap_wdata;
              end
            end else begin
              o_rdata <= in_range ? mem[cap_addr] : '0;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fsm_bus_responder.sv
// Scoreboard bench for fsm_bus_responder; honours BUS_RESP_ERR_EN when defined.
`default_nettype none

module tb_fsm_bus_responder;

  localparam int TB_WAIT  = 2;
  localparam int TB_DEPTH = 12;

  typedef struct {
    int         due;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel, write;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ok;
  logic [2:0] stat;
`ifdef BUS_RESP_ERR_EN
  logic       err;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sbq[$];
  logic [7:0] model_mem [16];
  logic [7:0] model_rdata;

  fsm_bus_responder #(.WAIT_CYCLES(TB_WAIT), .ADDR_W(4), .DATA_W(8), .DEPTH(TB_DEPTH)) u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sel          (sel),
    .i_write        (write),
    .i_addr         (addr),
    .i_wdata        (wdata),
    .o_rdata        (rdata),
    .o_ok           (ok),
`ifdef BUS_RESP_ERR_EN
    .o_err          (err),
`endif
    .o_stat_current (stat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_rdata = 8'h00;
  endtask

  // Predict the response of one transaction and queue it, due at ACK.
  task automatic push_exp(input logic w, input logic [3:0] a, input logic [7:0] d, input int cap_cyc);
    exp_t e;
    if (w) begin
      if (a < TB_DEPTH) model_mem[a] = d;
    end else begin
      model_rdata = (a < TB_DEPTH) ? model_mem[a] : 8'h00;
    end
    e.due   = cap_cyc + TB_WAIT + 1;
    e.rdata = model_rdata;
    e.err   = (a >= TB_DEPTH);
    sbq.push_back(e);
  endtask

  // Single transaction; inputs are scrambled and sel dropped while BUSY.
  task automatic do_txn(input logic w, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    sel = 1'b1; write = w; addr = a; wdata = d;
    push_exp(w, a, d, cyc + 1);
    @(posedge clk);
    @(negedge clk);
    check("stat_busy", stat, 3'b010);
    sel = 1'b0; write = ~w; addr = 4'($urandom); wdata = 8'($urandom);
    repeat (TB_WAIT + 3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ok) begin
        check("stat_ack", stat, 3'b011);
        if (sbq.size() == 0) begin
          check("ok_spurious", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("ok_cycle", cyc, e.due);
          check("rdata", rdata, e.rdata);
`ifdef BUS_RESP_ERR_EN
          check("err", err, e.err);
`endif
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
        check("ok_missing", 0, 1);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_stat", stat, 3'b000);
    check("rst_ok", ok, 0);
    check("rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    #1 check("rel_stat", stat, 3'b000);
    @(negedge clk);
    check("idle_stat", stat, 3'b001);
    check("idle_ok", ok, 0);

    // Basic write then read-back.
    do_txn(1'b1, 4'd3, 8'hA5);
    do_txn(1'b0, 4'd3, 8'h00);

    // Back-to-back writes with sel held high; next values shown during BUSY.
    @(negedge clk);
    sel = 1'b1; write = 1'b1; addr = 4'd0; wdata = 8'h11;
    push_exp(1'b1, 4'd0, 8'h11, cyc + 1);
    @(posedge clk);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      addr = 4'(k); wdata = 8'(8'h11 * (k + 1));
      push_exp(1'b1, 4'(k), 8'(8'h11 * (k + 1)), cyc + TB_WAIT + 3);
      repeat (TB_WAIT + 3) @(posedge clk);
    end
    @(negedge clk);
    sel = 1'b0;
    repeat (TB_WAIT + 3) @(negedge clk);
    for (int k = 0; k < 3; k++) do_txn(1'b0, 4'(k), 8'h00);

    // Out-of-range accesses; addr 13 must not alias onto addr 1.
    do_txn(1'b0, 4'd13, 8'h00);
    do_txn(1'b1, 4'd13, 8'hEE);
    do_txn(1'b0, 4'd1, 8'h00);
    do_txn(1'b0, 4'd13, 8'h00);

    // Reset in the middle of a write aborts it and clears storage.
    do_txn(1'b1, 4'd5, 8'h77);
    @(negedge clk);
    sel = 1'b1; write = 1'b1; addr = 4'd5; wdata = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_stat", stat, 3'b000);
    check("mid_rst_ok", ok, 0);
    check("mid_rst_rdata", rdata, 8'h00);
    for (int i = 0; i < TB_WAIT + 3; i++) begin
      @(negedge clk);
      check("rst_hold_ok", ok, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rerel_stat", stat, 3'b001);
    do_txn(1'b0, 4'd5, 8'h00);
    do_txn(1'b0, 4'd3, 8'h00);

    repeat (TB_WAIT + 4) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
